// File: rtl/or_serial_sequencer.sv
// or_serial_sequencer: bit-serial OR / OR-reduction engine built on a single 1-bit _or gate.
module or_serial_sequencer #(
   parameter int WIDTH = 16,
   parameter int IDXW  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d, out_q, out_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             op_q, op_d, acc_q, acc_d, g_a, g_b, g_y, last;
   assign last  = idx_q == IDXW'(WIDTH-1);
   assign g_a   = op_q ? acc_q : a_q[idx_q];
   assign g_b   = op_q ? a_q[idx_q] : b_q[idx_q];
   assign ready = state_q == IDLE;
   assign busy  = state_q == RUN;
   assign done  = state_q == DONE;
   assign out   = out_q;
   _or u_or (.a(g_a), .b(g_b), .out(g_y));
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      idx_d   = idx_q;
      work_d  = work_q;
      acc_d   = acc_q;
      out_d   = out_q;
      if (state_q == IDLE && start) begin
         a_d     = a;
         b_d     = b;
         op_d    = op;
         idx_d   = '0;
         work_d  = '0;
         acc_d   = 1'b0;
         state_d = RUN;
      end else if (state_q == RUN) begin
         if (op_q) acc_d = g_y;
         else work_d[idx_q] = g_y;
         idx_d = last ? '0 : idx_q + IDXW'(1);
         // the final bit is merged combinationally so out captures it on the exit edge
         if (last) begin
            state_d = DONE;
            out_d   = op_q ? {{(WIDTH-1){1'b0}}, acc_d} : work_d;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 1'b0;
         idx_q   <= '0;
         work_q  <= '0;
         acc_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         work_q  <= work_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
      end
   end
endmodule

module _or (
   input  logic a,
   input  logic b,
   output logic out
);
   assign out = a | b;
endmodule

// File: tb/tb_or_serial_sequencer.sv
// tb_or_serial_sequencer: directed vectors; expected results queued at issue, checked by a done monitor.
module tb_or_serial_sequencer;
   logic        clk = 1'b0, reset, start, op, ready, busy, done;
   logic [15:0] a, b, out;
   logic [15:0] exp_q[$];
   logic [3:0]  tt;
   int          vectors = 0, miscompares = 0, n, dones;

   always #5 clk = ~clk;

   or_serial_sequencer #(.WIDTH(16), .IDXW(4)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .ready(ready), .busy(busy), .done(done), .out(out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   always @(negedge clk)
      if (done === 1'b1) begin
         if (exp_q.size() == 0) check("unexpected_done", {31'd0, done}, 0);
         else check("out_at_done", {16'd0, out}, {16'd0, exp_q.pop_front()});
      end

   task automatic run_op(input logic o, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] expv, input logic [15:0] prev);
      int bad = 0;
      n = 0;
      while (ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      check("ready_wait", {31'd0, ready}, 1);
      start = 1'b1; op = o; a = av; b = bv;
      exp_q.push_back(expv);
      @(posedge clk); #1;
      start = 1'b0; a = 16'hAAAA; b = 16'h5555; op = ~o;
      for (int i = 1; i <= 18; i++) begin
         @(negedge clk);
         if (busy !== (i <= 16) || done !== (i == 17) || ready !== (i == 18)) bad++;
         if (i == 8 && out !== prev) bad++;
      end
      check("latency_and_hold", bad, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'd0, ready}, 1);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_out", {16'd0, out}, 0);
      reset = 1'b0;
      run_op(1'b0, 16'h00F0, 16'h0F01, 16'h0FF1, 16'h0000);
      repeat (3) @(negedge clk);
      check("out_hold", {16'd0, out}, 32'h0FF1);
      run_op(1'b1, 16'h0000, 16'h1234, 16'h0000, 16'h0FF1);
      run_op(1'b1, 16'h8000, 16'h0000, 16'h0001, 16'h0000);
      run_op(1'b1, 16'h0001, 16'hFFFF, 16'h0001, 16'h0001);
      run_op(1'b0, 16'h0003, 16'h0005, 16'h0007, 16'h0001);
      tt = 4'b0111;
      for (int i = 0; i < 4; i++) check("or_truth_bit", {31'd0, out[i]}, {31'd0, tt[i]});
      // start held high through RUN/DONE: one done, then a fresh accept from IDLE
      start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h0000;
      exp_q.push_back(16'h1234);
      exp_q.push_back(16'hFFFF);
      @(posedge clk); #1;
      a = 16'hFFFF;
      dones = 0;
      for (int i = 1; i <= 18; i++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      check("single_done", dones, 1);
      check("ready_with_start_high", {31'd0, ready}, 1);
      @(posedge clk); #1;
      start = 1'b0;
      check("second_accept", {31'd0, busy}, 1);
      n = 0;
      while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      check("second_done_seen", {31'd0, done}, 1);
      @(negedge clk);
      // abort an op partway through RUN
      start = 1'b1; op = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_ready", {31'd0, ready}, 1);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_done", {31'd0, done}, 0);
      check("abort_out", {16'd0, out}, 0);
      start = 1'b1;
      @(posedge clk); #1;
      check("rst_beats_start_busy", {31'd0, busy}, 0);
      check("rst_beats_start_ready", {31'd0, ready}, 1);
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_out_stays", {16'd0, out}, 0);
      run_op(1'b0, 16'h00F0, 16'h0F01, 16'h0FF1, 16'h0000);
      run_op(1'b1, 16'h0400, 16'h0000, 16'h0001, 16'h0FF1);
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin @(negedge clk); n++; end
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/or_serial_sequencer.md
Name: or_serial_sequencer

Overview:
- Time-multiplexes a single 1-bit `_or` gate instance to compute WIDTH-bit results serially, one bit per clock.
- Two operations:
  - bitwise Or16-style: out = a | b
  - Or-N-Way reduction: out[0] = |a
- Part of the sequential-chip layer, sitting above the combinational gate library.
- Driven by a start/ready/done handshake; the datapath is exactly one `_or` instance.

Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- IDXW, 4, index counter width; must satisfy 2^IDXW ≥ WIDTH.

Ports:
- clk, input, 1, rising-edge clock; the single clock domain.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, request to begin an operation; sampled only when ready=1.
- op, input, 1, operation select: 0 = bitwise OR of a and b, 1 = OR-reduction of a (b ignored).
- a, input, WIDTH, operand A; captured when start is accepted.
- b, input, WIDTH, operand B; captured when start is accepted.
- ready, output, 1, high in IDLE; start is accepted only when ready=1.
- busy, output, 1, high while bits are being processed (RUN).
- done, output, 1, single-cycle pulse; out is valid in the same cycle.
- out, output, WIDTH, result register; holds its value until the next completion or reset.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - Reset is synchronous and active-high (reset).
  - When reset=1 at a clk edge: state=IDLE, ready=1, busy=0, done=0, out=0, idx=0, accumulator=0.
  - Reset mid-operation aborts the operation with no partial write to out.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On start=1: latch a_r=a, b_r=b, op_r=op; clear idx and the working register; go to RUN.
  - On start=0: stay in IDLE.
- RUN (busy=1, ready=0), per cycle:
  - The `_or` instance inputs are driven as follows:
    - op_r=0: inputs are a_r[idx] and b_r[idx]; the gate output is written to work[idx].
    - op_r=1: inputs are acc and a_r[idx]; the gate output is written to acc.
  - idx increments every cycle.
  - When idx=WIDTH-1 is processed, go to DONE.
  - There is no early exit; reduction always takes WIDTH cycles.
- Completion write:
  - On the RUN→DONE edge, out is loaded:
    - op_r=0: work.
    - op_r=1: {WIDTH-1 zeros, acc}.
- DONE:
  - done=1 for exactly one cycle; ready=0, busy=0.
  - Unconditionally returns to IDLE.
- Latency:
  - start sampled at edge E0.
  - busy is high for the WIDTH cycles after E0.
  - done is high in cycle WIDTH+1 after E0 (17 for the default width).
  - Earliest next accepted start: the edge ending the DONE cycle + 1, i.e. one cycle with ready=1 first.
  - Throughput: one op per WIDTH+2 cycles.
- Ignored inputs:
  - start during RUN or DONE is ignored: no queueing, no error.
  - Changes to a, b, op after acceptance have no effect.
- Reset precedence: reset asserted together with start → reset wins; start is not accepted.
- Wrap-around: idx never exceeds WIDTH-1; the idx=WIDTH-1 exit condition is checked, not an overflow of idx.
- Outputs ready, busy and done are decoded from state and are mutually exclusive.
- out changes only on the completion edge or on reset.

Test Plan:
- Bitwise OR, WIDTH=16:
  - Stimulus: reset 2 cycles; start=1, op=0, a=0x00F0, b=0x0F01 for one cycle.
  - Required: busy high for 16 cycles; done pulse 17 cycles after start; out=0x0FF1 at done; ready returns the next cycle; out holds 0x0FF1 afterward.
- Reduction:
  - op=1, a=0x0000 → out=0x0000 at done.
  - op=1, a=0x8000 → out=0x0001 (MSB processed last).
  - op=1, a=0x0001, b=0xFFFF → out=0x0001 (b ignored).
- Exhaustive gate truth:
  - op=0 with a=0x0003, b=0x0005 (covers all four bit combinations 00/01/10/11 across bits 3..0).
  - Required: out=0x0007; all four bit pairs checked against the OR truth table.
- Ignored start:
  - After accepting a=0x1234, b=0x0000, op=0: hold start=1 throughout RUN with a=0xFFFF.
  - Required: out=0x1234 at done; exactly one done pulse before IDLE.
  - Then, with start still high in IDLE: a second op is accepted.
- Reset mid-op and precedence:
  - Assert reset at RUN cycle 8 of a=0xFFFF op.
  - Required: next cycle ready=1, busy=0, done=0, out=0x0000; no done pulse.
  - reset=1 and start=1 together → remains IDLE.
- Back-to-back:
  - Issue start in the first ready cycle after done, with op=1, a=0x0400.
  - Required: second done 17 cycles later with out=0x0001; the previous out is held until then.
